s2_axi_mem: RTL and testbench

S2_AXI_MEM -- requirements
Module: s2_axi_mem

---
 rtl/s2_axi_mem_pkg.sv | 51 +++++
 rtl/s2_axi_mem_array.sv | 29 ++
 rtl/s2_axi_mem.sv | 244 ++++++++++++++++++++++++
 tb/tb_s2_axi_mem.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2_axi_mem_pkg.sv
// Shared AXI widths, encodings, FSM state types and command helpers for the S2 memory slave.
package s2_axi_mem_pkg;

   localparam int unsigned AXI_ID_WIDTH     = 4;
   localparam int unsigned AXI_ADDR_WIDTH   = 32;
   localparam int unsigned AXI_DATA_WIDTH   = 32;
   localparam int unsigned AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8;
   localparam int unsigned AXI_USER_WIDTH   = 1;
   localparam int unsigned AXI_LEN_WIDTH    = 8;
   localparam int unsigned AXI_SIZE_WIDTH   = 3;
   localparam int unsigned AXI_BURST_WIDTH  = 2;
   localparam int unsigned AXI_CACHE_WIDTH  = 4;
   localparam int unsigned AXI_PROT_WIDTH   = 3;
   localparam int unsigned AXI_QOS_WIDTH    = 4;
   localparam int unsigned AXI_REGION_WIDTH = 4;
   localparam int unsigned AXI_RESP_WIDTH   = 2;
   localparam int unsigned AXI_ADDR_LSB     = $clog2(AXI_STRB_WIDTH);
   localparam int unsigned WBEAT_WIDTH      = 4;

   localparam logic [AXI_BURST_WIDTH-1:0] BURST_FIXED = 2'b00;
   localparam logic [AXI_BURST_WIDTH-1:0] BURST_INCR  = 2'b01;
   localparam logic [AXI_BURST_WIDTH-1:0] BURST_WRAP  = 2'b10;
   localparam logic [AXI_BURST_WIDTH-1:0] BURST_RSVD  = 2'b11;

   localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]    id;
      logic [AXI_ADDR_WIDTH-1:0]  addr;
      logic [AXI_LEN_WIDTH-1:0]   len;
      logic [AXI_SIZE_WIDTH-1:0]  size;
      logic [AXI_BURST_WIDTH-1:0] burst;
   } axi_cmd_t;

   // Bursts this slave cannot serve: WRAP, reserved encoding, or beats wider than the bus.
   function automatic logic cmd_err(input logic [AXI_BURST_WIDTH-1:0] burst,
                                    input logic [AXI_SIZE_WIDTH-1:0]  size);
      return (burst == BURST_WRAP) || (burst == BURST_RSVD) ||
             (size > AXI_SIZE_WIDTH'(AXI_ADDR_LSB));
   endfunction

   function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input axi_cmd_t c);
      if (c.burst == BURST_INCR) return c.addr + (AXI_ADDR_WIDTH'(1) << c.size);
      return c.addr;
   endfunction

endpackage

// File: rtl/s2_axi_mem_array.sv
// Word-wide storage with per-byte synchronous write and combinational read; contents are not reset.
module s2_mem_array #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   localparam int unsigned DEPTH      = 1 << DEPTH_LOG2
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [STRB_WIDTH-1:0] wstrb_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/s2_axi_mem.sv
// AXI4 memory slave on NoC port S2: independent write and read FSMs sharing one byte-enabled array.
module s2_axi_mem
   import s2_axi_mem_pkg::*;
#(
   parameter int unsigned MEM_DEPTH_LOG2 = 10,
   parameter bit          RD_LATENCY_EN  = 1'b0
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic [AXI_ID_WIDTH-1:0]     S2_AWID,
   input  logic [AXI_ADDR_WIDTH-1:0]   S2_AWADDR,
   input  logic [AXI_LEN_WIDTH-1:0]    S2_AWLEN,
   input  logic [AXI_SIZE_WIDTH-1:0]   S2_AWSIZE,
   input  logic [AXI_BURST_WIDTH-1:0]  S2_AWBURST,
   input  logic                        S2_AWLOCK,
   input  logic [AXI_CACHE_WIDTH-1:0]  S2_AWCACHE,
   input  logic [AXI_PROT_WIDTH-1:0]   S2_AWPROT,
   input  logic [AXI_QOS_WIDTH-1:0]    S2_AWQOS,
   input  logic [AXI_REGION_WIDTH-1:0] S2_AWREGION,
   input  logic [AXI_USER_WIDTH-1:0]   S2_AWUSER,
   input  logic                        S2_AWVALID,
   output logic                        S2_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   S2_WDATA,
   input  logic [AXI_STRB_WIDTH-1:0]   S2_WSTRB,
   input  logic                        S2_WLAST,
   input  logic                        S2_WVALID,
   input  logic [AXI_USER_WIDTH-1:0]   S2_WUSER,
   output logic                        S2_WREADY,
   output logic [AXI_ID_WIDTH-1:0]     S2_BID,
   output logic [AXI_RESP_WIDTH-1:0]   S2_BRESP,
   output logic                        S2_BVALID,
   output logic [AXI_USER_WIDTH-1:0]   S2_BUSER,
   input  logic                        S2_BREADY,
   input  logic [AXI_ID_WIDTH-1:0]     S2_ARID,
   input  logic [AXI_ADDR_WIDTH-1:0]   S2_ARADDR,
   input  logic [AXI_LEN_WIDTH-1:0]    S2_ARLEN,
   input  logic [AXI_SIZE_WIDTH-1:0]   S2_ARSIZE,
   input  logic [AXI_BURST_WIDTH-1:0]  S2_ARBURST,
   input  logic                        S2_ARLOCK,
   input  logic [AXI_CACHE_WIDTH-1:0]  S2_ARCACHE,
   input  logic [AXI_PROT_WIDTH-1:0]   S2_ARPROT,
   input  logic [AXI_QOS_WIDTH-1:0]    S2_ARQOS,
   input  logic [AXI_REGION_WIDTH-1:0] S2_ARREGION,
   input  logic [AXI_USER_WIDTH-1:0]   S2_ARUSER,
   input  logic                        S2_ARVALID,
   output logic                        S2_ARREADY,
   output logic [AXI_ID_WIDTH-1:0]     S2_RID,
   output logic [AXI_DATA_WIDTH-1:0]   S2_RDATA,
   output logic [AXI_RESP_WIDTH-1:0]   S2_RRESP,
   output logic                        S2_RLAST,
   output logic                        S2_RVALID,
   output logic [AXI_USER_WIDTH-1:0]   S2_RUSER,
   input  logic                        S2_RREADY
);

   // ---------------- write channel ----------------
   w_state_e                   w_state_q, w_state_d;
   axi_cmd_t                   aw_q, aw_d;
   logic [WBEAT_WIDTH-1:0]     wbeat_q, wbeat_d;
   logic                       werr_q, werr_d;
   logic                       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [AXI_ID_WIDTH-1:0]    bid_q, bid_d;
   logic [AXI_RESP_WIDTH-1:0]  bresp_q, bresp_d;
   logic                       aw_hs_c, w_hs_c, b_hs_c, mem_we_c;
   logic [AXI_LEN_WIDTH-1:0]   wbeat_ext_c;

   assign aw_hs_c     = S2_AWVALID && awready_q;
   assign w_hs_c      = S2_WVALID && wready_q;
   assign b_hs_c      = bvalid_q && S2_BREADY;
   assign wbeat_ext_c = AXI_LEN_WIDTH'(wbeat_q);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state_q <= W_IDLE;
         aw_q      <= '0;
         wbeat_q   <= '0;
         werr_q    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_q      <= aw_d;
         wbeat_q   <= wbeat_d;
         werr_q    <= werr_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (aw_hs_c)             w_state_d = W_DATA;
         W_DATA:  if (w_hs_c && S2_WLAST)  w_state_d = W_RESP;
         W_RESP:  if (b_hs_c)              w_state_d = W_IDLE;
         default:                          w_state_d = W_IDLE;
      endcase
   end

   // Early WLAST and missing WLAST both poison the response; only a bad burst shape blocks writes.
   always_comb begin
      aw_d     = aw_q;
      wbeat_d  = wbeat_q;
      werr_d   = werr_q;
      bid_d    = bid_q;
      bresp_d  = bresp_q;
      mem_we_c = 1'b0;
      if (aw_hs_c) begin
         aw_d    = '{id: S2_AWID, addr: S2_AWADDR, len: S2_AWLEN, size: S2_AWSIZE, burst: S2_AWBURST};
         wbeat_d = '0;
         werr_d  = cmd_err(S2_AWBURST, S2_AWSIZE);
      end
      if (w_hs_c) begin
         mem_we_c  = !cmd_err(aw_q.burst, aw_q.size);
         aw_d.addr = next_addr(aw_q);
         if (wbeat_q != '1) wbeat_d = wbeat_q + WBEAT_WIDTH'(1);
         if (S2_WLAST ? (wbeat_ext_c < aw_q.len) : (wbeat_ext_c >= aw_q.len)) werr_d = 1'b1;
         if (S2_WLAST) begin
            bid_d   = aw_q.id;
            bresp_d = werr_d ? RESP_SLVERR : RESP_OKAY;
         end
      end
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // ---------------- read channel ----------------
   r_state_e                   r_state_q, r_state_d;
   axi_cmd_t                   ar_q, ar_d;
   logic [AXI_LEN_WIDTH-1:0]   rbeat_q, rbeat_d;
   logic                       arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [AXI_ID_WIDTH-1:0]    rid_q, rid_d;
   logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d, mem_rdata_c;
   logic [AXI_RESP_WIDTH-1:0]  rresp_q, rresp_d;
   logic                       ar_hs_c, r_hs_c, r_load_c, r_err_c;

   assign ar_hs_c = S2_ARVALID && arready_q;
   assign r_hs_c  = rvalid_q && S2_RREADY;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state_q <= R_IDLE;
         ar_q      <= '0;
         rbeat_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         ar_q      <= ar_d;
         rbeat_q   <= rbeat_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs_c)             r_state_d = RD_LATENCY_EN ? R_WAIT : R_DATA;
         R_WAIT:                           r_state_d = R_DATA;
         R_DATA:  if (r_hs_c && rlast_q)   r_state_d = R_IDLE;
         default:                          r_state_d = R_IDLE;
      endcase
   end

   // Command/beat for the beat about to be presented; drives the array read address.
   always_comb begin
      ar_d    = ar_q;
      rbeat_d = rbeat_q;
      if (ar_hs_c) begin
         ar_d    = '{id: S2_ARID, addr: S2_ARADDR, len: S2_ARLEN, size: S2_ARSIZE, burst: S2_ARBURST};
         rbeat_d = '0;
      end else if (r_hs_c && !rlast_q) begin
         ar_d.addr = next_addr(ar_q);
         rbeat_d   = rbeat_q + AXI_LEN_WIDTH'(1);
      end
   end

   // Registering the beat at load time keeps it stable under stalls and gives read-before-write.
   assign r_load_c = (r_state_d == R_DATA) && ((r_state_q != R_DATA) || r_hs_c);
   assign r_err_c  = cmd_err(ar_d.burst, ar_d.size);

   always_comb begin
      rid_d   = rid_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      rlast_d = rlast_q;
      if (r_load_c) begin
         rid_d   = ar_d.id;
         rdata_d = r_err_c ? '0 : mem_rdata_c;
         rresp_d = r_err_c ? RESP_SLVERR : RESP_OKAY;
         rlast_d = (rbeat_d == ar_d.len);
      end
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   s2_mem_array #(
      .DEPTH_LOG2 (MEM_DEPTH_LOG2),
      .DATA_WIDTH (AXI_DATA_WIDTH)
   ) u_mem (
      .clk_i   (ACLK),
      .we_i    (mem_we_c),
      .waddr_i (aw_q.addr[AXI_ADDR_LSB +: MEM_DEPTH_LOG2]),
      .wdata_i (S2_WDATA),
      .wstrb_i (S2_WSTRB),
      .raddr_i (ar_d.addr[AXI_ADDR_LSB +: MEM_DEPTH_LOG2]),
      .rdata_o (mem_rdata_c)
   );

   assign S2_AWREADY = awready_q;
   assign S2_WREADY  = wready_q;
   assign S2_BVALID  = bvalid_q;
   assign S2_BID     = bid_q;
   assign S2_BRESP   = bresp_q;
   assign S2_BUSER   = '0;
   assign S2_ARREADY = arready_q;
   assign S2_RVALID  = rvalid_q;
   assign S2_RID     = rid_q;
   assign S2_RDATA   = rdata_q;
   assign S2_RRESP   = rresp_q;
   assign S2_RLAST   = rlast_q;
   assign S2_RUSER   = '0;

   logic unused_c;
   assign unused_c = ^{S2_AWLOCK, S2_AWCACHE, S2_AWPROT, S2_AWQOS, S2_AWREGION, S2_AWUSER, S2_WUSER,
                       S2_ARLOCK, S2_ARCACHE, S2_ARPROT, S2_ARQOS, S2_ARREGION, S2_ARUSER};

endmodule

// File: tb/tb_s2_axi_mem.sv
// Directed bench for s2_axi_mem: write/read bursts, strobes, error responses and reset behaviour.
module tb_s2_axi_mem;
   import s2_axi_mem_pkg::*;

   logic                        ACLK, ARESETn;
   logic [AXI_ID_WIDTH-1:0]     S2_AWID, S2_ARID, S2_BID, S2_RID;
   logic [AXI_ADDR_WIDTH-1:0]   S2_AWADDR, S2_ARADDR;
   logic [AXI_LEN_WIDTH-1:0]    S2_AWLEN, S2_ARLEN;
   logic [AXI_SIZE_WIDTH-1:0]   S2_AWSIZE, S2_ARSIZE;
   logic [AXI_BURST_WIDTH-1:0]  S2_AWBURST, S2_ARBURST;
   logic                        S2_AWLOCK, S2_ARLOCK;
   logic [AXI_CACHE_WIDTH-1:0]  S2_AWCACHE, S2_ARCACHE;
   logic [AXI_PROT_WIDTH-1:0]   S2_AWPROT, S2_ARPROT;
   logic [AXI_QOS_WIDTH-1:0]    S2_AWQOS, S2_ARQOS;
   logic [AXI_REGION_WIDTH-1:0] S2_AWREGION, S2_ARREGION;
   logic [AXI_USER_WIDTH-1:0]   S2_AWUSER, S2_ARUSER, S2_WUSER, S2_BUSER, S2_RUSER;
   logic                        S2_AWVALID, S2_AWREADY, S2_ARVALID, S2_ARREADY;
   logic [AXI_DATA_WIDTH-1:0]   S2_WDATA, S2_RDATA;
   logic [AXI_STRB_WIDTH-1:0]   S2_WSTRB;
   logic                        S2_WLAST, S2_WVALID, S2_WREADY;
   logic [AXI_RESP_WIDTH-1:0]   S2_BRESP, S2_RRESP;
   logic                        S2_BVALID, S2_BREADY, S2_RLAST, S2_RVALID, S2_RREADY;

   int checks = 0;
   int errors = 0;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [3:0]  b_id;
   logic [1:0]  b_resp, b_resp_late;
   logic        bvalid_late, awready_after, bvalid_after;
   logic [31:0] r_data [16];
   logic [1:0]  r_resp [16];
   logic        r_last [16];
   logic [3:0]  r_id   [16];
   int          r_n, stall_changes;
   logic        rvalid_after;

   s2_axi_mem dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .S2_AWID(S2_AWID), .S2_AWADDR(S2_AWADDR), .S2_AWLEN(S2_AWLEN), .S2_AWSIZE(S2_AWSIZE),
      .S2_AWBURST(S2_AWBURST), .S2_AWLOCK(S2_AWLOCK), .S2_AWCACHE(S2_AWCACHE), .S2_AWPROT(S2_AWPROT),
      .S2_AWQOS(S2_AWQOS), .S2_AWREGION(S2_AWREGION), .S2_AWUSER(S2_AWUSER), .S2_AWVALID(S2_AWVALID),
      .S2_AWREADY(S2_AWREADY),
      .S2_WDATA(S2_WDATA), .S2_WSTRB(S2_WSTRB), .S2_WLAST(S2_WLAST), .S2_WVALID(S2_WVALID),
      .S2_WUSER(S2_WUSER), .S2_WREADY(S2_WREADY),
      .S2_BID(S2_BID), .S2_BRESP(S2_BRESP), .S2_BVALID(S2_BVALID), .S2_BUSER(S2_BUSER),
      .S2_BREADY(S2_BREADY),
      .S2_ARID(S2_ARID), .S2_ARADDR(S2_ARADDR), .S2_ARLEN(S2_ARLEN), .S2_ARSIZE(S2_ARSIZE),
      .S2_ARBURST(S2_ARBURST), .S2_ARLOCK(S2_ARLOCK), .S2_ARCACHE(S2_ARCACHE), .S2_ARPROT(S2_ARPROT),
      .S2_ARQOS(S2_ARQOS), .S2_ARREGION(S2_ARREGION), .S2_ARUSER(S2_ARUSER), .S2_ARVALID(S2_ARVALID),
      .S2_ARREADY(S2_ARREADY),
      .S2_RID(S2_RID), .S2_RDATA(S2_RDATA), .S2_RRESP(S2_RRESP), .S2_RLAST(S2_RLAST),
      .S2_RVALID(S2_RVALID), .S2_RUSER(S2_RUSER), .S2_RREADY(S2_RREADY)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int i = 0;
      S2_AWID = id; S2_AWADDR = addr; S2_AWLEN = len; S2_AWSIZE = size; S2_AWBURST = burst;
      S2_AWVALID = 1'b1;
      while (!S2_AWREADY && i < 50) begin @(negedge ACLK); i++; end
      if (!S2_AWREADY) begin checks++; errors++; $display("FAIL aw_timeout got AWREADY=0 expected 1"); end
      @(negedge ACLK);
      S2_AWVALID = 1'b0;
   endtask

   task automatic send_w(input int n);
      for (int b = 0; b < n; b++) begin
         int i = 0;
         S2_WDATA = wd[b]; S2_WSTRB = ws[b]; S2_WLAST = (b == n - 1); S2_WVALID = 1'b1;
         while (!S2_WREADY && i < 50) begin @(negedge ACLK); i++; end
         if (!S2_WREADY) begin checks++; errors++; $display("FAIL w_timeout got WREADY=0 expected 1"); end
         @(negedge ACLK);
      end
      S2_WVALID = 1'b0; S2_WLAST = 1'b0;
   endtask

   task automatic recv_b(input int hold);
      int i = 0;
      while (!S2_BVALID && i < 50) begin @(negedge ACLK); i++; end
      if (!S2_BVALID) begin checks++; errors++; $display("FAIL b_timeout got BVALID=0 expected 1"); end
      b_id = S2_BID; b_resp = S2_BRESP;
      repeat (hold) @(negedge ACLK);
      b_resp_late = S2_BRESP; bvalid_late = S2_BVALID;
      S2_BREADY = 1'b1;
      @(negedge ACLK);
      S2_BREADY = 1'b0;
      awready_after = S2_AWREADY; bvalid_after = S2_BVALID;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int i = 0;
      S2_ARID = id; S2_ARADDR = addr; S2_ARLEN = len; S2_ARSIZE = size; S2_ARBURST = burst;
      S2_ARVALID = 1'b1;
      while (!S2_ARREADY && i < 50) begin @(negedge ACLK); i++; end
      if (!S2_ARREADY) begin checks++; errors++; $display("FAIL ar_timeout got ARREADY=0 expected 1"); end
      @(negedge ACLK);
      S2_ARVALID = 1'b0;
   endtask

   // Collects every R beat; with toggle set RREADY alternates low/high and stalled beats are watched.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
      bit phase = 1'b0, have_snap = 1'b0, done = 1'b0;
      logic [31:0] sd; logic [1:0] sr; logic sl;
      int guard = 0;
      send_ar(id, addr, len, size, burst);
      r_n = 0; stall_changes = 0;
      while (!done && guard < 200) begin
         if (S2_RVALID) begin
            if (have_snap && (S2_RDATA !== sd || S2_RRESP !== sr || S2_RLAST !== sl)) stall_changes++;
            if (!toggle || phase) begin
               S2_RREADY = 1'b1;
               if (r_n < 16) begin
                  r_data[r_n] = S2_RDATA; r_resp[r_n] = S2_RRESP;
                  r_last[r_n] = S2_RLAST; r_id[r_n]   = S2_RID;
               end
               r_n++; have_snap = 1'b0; done = S2_RLAST;
            end else begin
               S2_RREADY = 1'b0;
               sd = S2_RDATA; sr = S2_RRESP; sl = S2_RLAST; have_snap = 1'b1;
            end
            phase = !phase;
         end else begin
            S2_RREADY = 1'b0;
         end
         @(negedge ACLK);
         guard++;
      end
      S2_RREADY = 1'b0;
      if (!done) begin checks++; errors++; $display("FAIL r_timeout got no RLAST beat, expected one"); end
      rvalid_after = S2_RVALID;
   endtask

   task automatic test_reset();
      ARESETn = 1'b1;
      #2 ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      checks++;
      if ({S2_AWREADY, S2_WREADY, S2_BVALID, S2_ARREADY, S2_RVALID} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs got %b expected 00000",
                            {S2_AWREADY, S2_WREADY, S2_BVALID, S2_ARREADY, S2_RVALID});
      end
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      checks++;
      if ({S2_AWREADY, S2_ARREADY} !== 2'b11) begin
         errors++; $display("FAIL reset_ready got %b expected 11", {S2_AWREADY, S2_ARREADY});
      end
      @(negedge ACLK);
   endtask

   task automatic test_single();
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      send_aw(4'd3, 32'h100, 8'd0, 3'd2, BURST_INCR); send_w(1); recv_b(0);
      checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b expected 00", b_resp); end
      checks++; if (b_id !== 4'd3) begin errors++; $display("FAIL single_bid got %0d expected 3", b_id); end
      do_read(4'd2, 32'h100, 8'd0, 3'd2, BURST_INCR, 1'b0);
      checks++; if (r_n !== 1) begin errors++; $display("FAIL single_nbeats got %0d expected 1", r_n); end
      checks++; if (r_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h expected deadbeef", r_data[0]); end
      checks++; if ({r_last[0], r_resp[0], r_id[0]} !== {1'b1, 2'b00, 4'd2}) begin
         errors++; $display("FAIL single_rlast_resp_id got %b/%b/%0d expected 1/00/2", r_last[0], r_resp[0], r_id[0]);
      end
   endtask

   task automatic test_incr_burst();
      for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
      send_aw(4'd1, 32'h0, 8'd3, 3'd2, BURST_INCR); send_w(4); recv_b(0);
      checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b expected 00", b_resp); end
      do_read(4'd4, 32'h0, 8'd3, 3'd2, BURST_INCR, 1'b1);
      checks++; if (r_n !== 4) begin errors++; $display("FAIL incr_nbeats got %0d expected 4", r_n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (r_data[i] !== 32'(i + 1) || r_last[i] !== (i == 3) || r_resp[i] !== 2'b00) begin
            errors++; $display("FAIL incr_beat%0d got data=%h last=%b resp=%b expected data=%h last=%b resp=00",
                               i, r_data[i], r_last[i], r_resp[i], 32'(i + 1), (i == 3));
         end
      end
      checks++; if (stall_changes !== 0) begin errors++; $display("FAIL incr_stall_stable got %0d changes expected 0", stall_changes); end
      checks++; if (rvalid_after !== 1'b0) begin errors++; $display("FAIL incr_no_extra_beat got RVALID=%b expected 0", rvalid_after); end
   endtask

   task automatic test_strobe_fixed();
      wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
      send_aw(4'd0, 32'h200, 8'd0, 3'd2, BURST_INCR); send_w(1); recv_b(0);
      wd[0] = 32'h11223344; ws[0] = 4'h1; wd[1] = 32'hAABBCCDD; ws[1] = 4'h8;
      send_aw(4'd6, 32'h200, 8'd1, 3'd2, BURST_FIXED); send_w(2); recv_b(0);
      checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got %b expected 00", b_resp); end
      do_read(4'd0, 32'h200, 8'd0, 3'd2, BURST_INCR, 1'b0);
      checks++; if (r_data[0] !== 32'hAAFFFF44) begin errors++; $display("FAIL fixed_rdata got %h expected aaffff44", r_data[0]); end
   endtask

   task automatic test_wrap_err();
      wd[0] = 32'h0; ws[0] = 4'hF; wd[1] = 32'h0; ws[1] = 4'hF;
      send_aw(4'd7, 32'h200, 8'd1, 3'd2, BURST_WRAP); send_w(2); recv_b(0);
      checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp got %b expected 10", b_resp); end
      do_read(4'd0, 32'h200, 8'd0, 3'd2, BURST_INCR, 1'b0);
      checks++; if (r_data[0] !== 32'hAAFFFF44) begin errors++; $display("FAIL wrap_mem_unchanged got %h expected aaffff44", r_data[0]); end
   endtask

   task automatic test_wlast_early();
      wd[0] = 32'h1; ws[0] = 4'hF; wd[1] = 32'h2; ws[1] = 4'hF;
      send_aw(4'd9, 32'h300, 8'd3, 3'd2, BURST_INCR); send_w(2); recv_b(2);
      checks++; if ({b_resp, b_id} !== {2'b10, 4'd9}) begin errors++; $display("FAIL early_bresp_bid got %b/%0d expected 10/9", b_resp, b_id); end
      checks++; if ({bvalid_late, b_resp_late} !== 3'b110) begin
         errors++; $display("FAIL early_b_hold got valid=%b resp=%b expected 1/10", bvalid_late, b_resp_late);
      end
      checks++; if ({awready_after, bvalid_after} !== 2'b10) begin
         errors++; $display("FAIL early_after_b got awready=%b bvalid=%b expected 1/0", awready_after, bvalid_after);
      end
   endtask

   task automatic test_wlast_late();
      wd[0] = 32'h5; ws[0] = 4'hF; wd[1] = 32'h6; ws[1] = 4'hF;
      send_aw(4'd2, 32'h400, 8'd0, 3'd2, BURST_INCR); send_w(2); recv_b(0);
      checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL late_bresp got %b expected 10", b_resp); end
   endtask

   task automatic test_ar_size_err();
      do_read(4'd8, 32'h0, 8'd0, 3'd3, BURST_INCR, 1'b0);
      checks++; if ({r_resp[0], r_data[0], r_last[0]} !== {2'b10, 32'h0, 1'b1}) begin
         errors++; $display("FAIL arsize_err got resp=%b data=%h last=%b expected 10/00000000/1", r_resp[0], r_data[0], r_last[0]);
      end
   endtask

   task automatic test_addr_wrap();
      wd[0] = 32'h5A5A0001; ws[0] = 4'hF;
      send_aw(4'd1, 32'h1010, 8'd0, 3'd2, BURST_INCR); send_w(1); recv_b(0);
      do_read(4'd1, 32'h10, 8'd0, 3'd2, BURST_INCR, 1'b0);
      checks++; if (r_data[0] !== 32'h5A5A0001) begin errors++; $display("FAIL addr_wrap got %h expected 5a5a0001", r_data[0]); end
   endtask

   task automatic test_reset_mid_read();
      send_ar(4'd7, 32'h0, 8'd7, 3'd2, BURST_INCR);
      S2_RREADY = 1'b1;
      repeat (2) @(negedge ACLK);
      checks++; if ({S2_RVALID, S2_RDATA} !== {1'b1, 32'd3}) begin
         errors++; $display("FAIL midread_beat2 got valid=%b data=%h expected 1/00000003", S2_RVALID, S2_RDATA);
      end
      S2_RREADY = 1'b0;
      #1 ARESETn = 1'b0;
      #1;
      checks++; if ({S2_RVALID, S2_ARREADY} !== 2'b00) begin
         errors++; $display("FAIL midread_reset got rvalid=%b arready=%b expected 0/0", S2_RVALID, S2_ARREADY);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);
      do_read(4'd5, 32'h100, 8'd0, 3'd2, BURST_INCR, 1'b0);
      checks++; if ({r_n == 1, r_id[0], r_data[0]} !== {1'b1, 4'd5, 32'hDEADBEEF}) begin
         errors++; $display("FAIL post_reset_read got n=%0d id=%0d data=%h expected 1/5/deadbeef", r_n, r_id[0], r_data[0]);
      end
      checks++; if (rvalid_after !== 1'b0) begin errors++; $display("FAIL post_reset_stale got RVALID=%b expected 0", rvalid_after); end
   endtask

   initial begin
      S2_AWID = '0; S2_AWADDR = '0; S2_AWLEN = '0; S2_AWSIZE = '0; S2_AWBURST = '0; S2_AWLOCK = 1'b0;
      S2_AWCACHE = '0; S2_AWPROT = '0; S2_AWQOS = '0; S2_AWREGION = '0; S2_AWUSER = '0; S2_AWVALID = 1'b0;
      S2_WDATA = '0; S2_WSTRB = '0; S2_WLAST = 1'b0; S2_WVALID = 1'b0; S2_WUSER = '0; S2_BREADY = 1'b0;
      S2_ARID = '0; S2_ARADDR = '0; S2_ARLEN = '0; S2_ARSIZE = '0; S2_ARBURST = '0; S2_ARLOCK = 1'b0;
      S2_ARCACHE = '0; S2_ARPROT = '0; S2_ARQOS = '0; S2_ARREGION = '0; S2_ARUSER = '0; S2_ARVALID = 1'b0;
      S2_RREADY = 1'b0;
      test_reset();
      test_single();
      test_incr_burst();
      test_strobe_fixed();
      test_wrap_err();
      test_wlast_early();
      test_wlast_late();
      test_ar_size_err();
      test_addr_wrap();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
